// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Serial parity frame transmitter. A parallel WIDTH-bit word is shifted out
// LSB first while `frame` is high. One parity bit follows, with `par_valid`
// and `done` asserted. That bit is the XOR of all data bits, so it is 1 when
// the word holds an odd count of ones.
//
// Optional feature: define PARITY_FRAME_TX_SKID_EN to add a one-word holding
// register. With it, a second word can be accepted while a frame is in flight,
// and frames stream back-to-back with a single low `frame` cycle between them.
//
// Timing note: the internal state register runs one cycle ahead of the
// registered outputs. The outputs driven at an edge are decided by the state
// that was current before that edge. Because of this, a load accepted at
// edge k shows its first bit at edge k+1, and `ready` can be decoded from the
// leading state without any combinational path to the outputs.

module parity_frame_tx #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             frame,
    output logic             bit_out,
    output logic             par_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    cnt;
    logic             acc;

    // A word is taken only when the registered ready was high this cycle.
    logic accept;
    assign accept = load & ready;

`ifdef PARITY_FRAME_TX_SKID_EN
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    // Frame sequencer with skid buffer: shift-out, parity append, and the
    // holding register that lets the next word start right after parity.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            ready     <= 1'b0;
            frame     <= 1'b0;
            bit_out   <= 1'b0;
            par_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            frame     <= 1'b0;
            bit_out   <= 1'b0;
            par_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    // The holding register is always empty here: it drains
                    // in PARITY. So an accepted word goes straight to shift.
                    ready <= 1'b1;
                    if (accept) begin
                        shift <= data_in;
                        cnt   <= '0;
                        acc   <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    frame   <= 1'b1;
                    bit_out <= shift[0];
                    shift   <= shift >> 1;
                    acc     <= acc ^ shift[0];
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT)
                        state <= PARITY;
                    if (accept) begin
                        hold      <= data_in;
                        hold_full <= 1'b1;
                        ready     <= 1'b0;
                    end else begin
                        ready     <= ~hold_full;
                    end
                end
                PARITY: begin
                    par_valid <= 1'b1;
                    done      <= 1'b1;
                    bit_out   <= acc;
                    ready     <= 1'b1;
                    state     <= IDLE;
                    // A pending word starts immediately. Only one parity
                    // cycle separates the frames.
                    if (hold_full) begin
                        shift     <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                        acc       <= 1'b0;
                        state     <= DATA;
                    end else if (accept) begin
                        shift <= data_in;
                        cnt   <= '0;
                        acc   <= 1'b0;
                        state <= DATA;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    // Frame sequencer: load, WIDTH data cycles, one parity cycle, back to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            ready     <= 1'b0;
            frame     <= 1'b0;
            bit_out   <= 1'b0;
            par_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            frame     <= 1'b0;
            bit_out   <= 1'b0;
            par_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= ~accept;
                    if (accept) begin
                        shift <= data_in;
                        cnt   <= '0;
                        acc   <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Loads arriving here are dropped; ready is low.
                    ready   <= 1'b0;
                    frame   <= 1'b1;
                    bit_out <= shift[0];
                    shift   <= shift >> 1;
                    acc     <= acc ^ shift[0];
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT)
                        state <= PARITY;
                end
                PARITY: begin
                    // The state is already IDLE after this edge, so ready
                    // rises together with the parity output cycle.
                    par_valid <= 1'b1;
                    done      <= 1'b1;
                    bit_out   <= acc;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx. It uses two instances: WIDTH=8 and
// WIDTH=64.
module tb_parity_frame_tx;

    logic        clock;
    logic        reset;
    logic        load8,  load64;
    logic [7:0]  din8;
    logic [63:0] din64;
    logic        r8, f8, b8, pv8, d8;
    logic        r64, f64, b64, pv64, d64;

    int checks = 0;
    int errors = 0;

    parity_frame_tx #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .load(load8), .data_in(din8),
        .ready(r8), .frame(f8), .bit_out(b8), .par_valid(pv8), .done(d8)
    );

    parity_frame_tx #(.WIDTH(64)) dut64 (
        .clock(clock), .reset(reset), .load(load64), .data_in(din64),
        .ready(r64), .frame(f64), .bit_out(b64), .par_valid(pv64), .done(d64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one 64-bit word. Check the serial data, the frame qualifier, the
    // parity cycle at k+65, and the idle cycle that follows.
    task automatic send64(input string tag, input logic [63:0] w, input logic exp_par);
        logic [63:0] got;
        logic        allf;
        logic        det;
        din64  = w;
        load64 = 1'b1;
        tick;
        load64 = 1'b0;
        got  = '0;
        allf = 1'b1;
        det  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick;
            got[i] = b64;
            allf   = allf & f64;
            if (f64) det = det ^ b64;
        end
        check({tag, " data"}, got, w);
        check({tag, " frame"}, 64'(allf), 64'(1'b1));
        tick;
        check({tag, " parity_cycle"}, 64'({f64, pv64, d64, b64}), 64'({1'b0, 1'b1, 1'b1, exp_par}));
        check({tag, " detector"}, 64'(det), 64'(exp_par));
        tick;
        check({tag, " idle"}, 64'({f64, d64, r64}), 64'(3'b001));
    endtask

    initial begin
        logic [7:0]  got8;
        logic        allf8;
        int          cnt;
        logic [63:0] w;
        logic [19:0] fv, bv, pv, rv;

        reset  = 1'b1;
        load8  = 1'b0;
        load64 = 1'b0;
        din8   = '0;
        din64  = '0;

        // Reset state
        tick;
        tick;
        check("reset_outs8",  64'({r8, f8, b8, pv8, d8}), 64'(0));
        check("reset_outs64", 64'({r64, f64, b64, pv64, d64}), 64'(0));
        reset = 1'b0;
        tick;
        check("ready_after_reset", 64'({r8, r64}), 64'(2'b11));

        // Single word 8'hB2: bits 0,1,0,0,1,1,0,1, then parity 0
        din8  = 8'hB2;
        load8 = 1'b1;
        tick;
        load8 = 1'b0;
        check("b2_no_frame_at_k", 64'(f8), 64'(0));
        got8  = '0;
        allf8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            got8[i] = b8;
            allf8   = allf8 & f8;
        end
        check("b2_bits", 64'(got8), 64'(8'hB2));
        check("b2_frame", 64'(allf8), 64'(1'b1));
        tick;
        check("b2_parity", 64'({f8, pv8, d8, b8}), 64'(4'b0110));
        tick;
        check("b2_idle", 64'({f8, pv8, d8, r8}), 64'(4'b0001));

        // 64-bit parity cases, hand-computed
        send64("w7", 64'h0000_0000_0000_0007, 1'b1);
        send64("ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send64("zeros", 64'h0, 1'b0);

`ifndef PARITY_FRAME_TX_SKID_EN
        // Busy rejection: 8'hFF pulsed at k+3 during an 8'h01 frame
        din8  = 8'h01;
        load8 = 1'b1;
        tick;
        load8 = 1'b0;
        got8  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                din8  = 8'hFF;
                load8 = 1'b1;
            end
            tick;
            load8   = 1'b0;
            got8[i] = b8;
        end
        check("busy_bits", 64'(got8), 64'(8'h01));
        tick;
        check("busy_parity", 64'({f8, pv8, d8, b8}), 64'(4'b0111));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (f8 || d8) cnt++;
        end
        check("busy_no_second_frame", 64'(cnt), 64'(0));
`else
        // Back-to-back: 8'h0F at k, 8'h01 at k+1; record edges k+1..k+20
        din8  = 8'h0F;
        load8 = 1'b1;
        tick;
        din8  = 8'h01;
        tick;
        load8 = 1'b0;
        fv = '0; bv = '0; pv = '0; rv = '0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick;
            fv[i] = f8;
            bv[i] = b8;
            pv[i] = pv8;
            rv[i] = r8;
        end
        check("b2b_frame", 64'(fv), 64'(20'h1FEFF));
        check("b2b_bits",  64'(bv), 64'(20'h2020F));
        check("b2b_parv",  64'(pv), 64'(20'h20100));
        check("b2b_ready", 64'(rv), 64'(20'hFFF00));
`endif

        // Reset for 3 cycles in the middle of a 64-bit frame
        din64  = 64'hDEAD_BEEF_0123_4567;
        load64 = 1'b1;
        tick;
        load64 = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_frame_active", 64'(f64), 64'(1'b1));
        reset = 1'b1;
        tick;
        check("mid_reset_outs", 64'({r64, f64, b64, pv64, d64}), 64'(0));
        tick;
        tick;
        check("mid_reset_ready_low", 64'(r64), 64'(0));
        reset = 1'b0;
        tick;
        check("mid_release_ready", 64'({r64, f64}), 64'(2'b10));
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick;
            if (f64 || d64 || pv64) cnt++;
        end
        check("abandoned_no_done", 64'(cnt), 64'(0));

        // Loopback: random words, parity bit against the detector-side model
        for (int n = 0; n < 30; n++) begin
            w = {$urandom(), $urandom()};
            send64("rand", w, ^w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
